// File: rtl/uart_rx_ext.sv
// Oversampled UART receiver with configurable width, parity and stop bits, plus framing/break detect.
// Define UART_RX_MAJORITY_EN to take every bit as a 2-of-3 majority around its sample point.
module uart_rx_ext #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    input  logic                 i_tick,
    output logic                 o_rx_done,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] C_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_DLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] C_SLAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_HOLD
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bcnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_pbit;
    logic                 r_ferr;

    logic [CW-1:0]        w_pt;
    logic                 w_at_pt;
    logic                 w_bit;
    logic                 w_ferr_nx;
    logic                 w_perr;
    logic                 w_brk;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_pt    = (r_state == S_START) ? C_HALF : C_FULL;
    assign w_at_pt = i_tick && (r_cnt == w_pt);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;

    // Two early samples at N-2 and N-1; the third is the live value at N.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_maj <= 2'b11;
        end else if (i_tick) begin
            if (r_cnt == w_pt - CW'(2)) r_maj[0] <= r_rx_s;
            if (r_cnt == w_pt - CW'(1)) r_maj[1] <= r_rx_s;
        end
    end

    assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_rx_s) | (r_maj[1] & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    assign w_ferr_nx = r_ferr | ~w_bit;
    assign w_perr    = (PARITY_MODE != 0) && ((^r_shreg ^ r_pbit) != (PARITY_MODE == 2));
    assign w_brk     = w_ferr_nx && (r_shreg == '0) && !r_pbit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bcnt       <= '0;
            r_shreg      <= '0;
            r_pbit       <= 1'b0;
            r_ferr       <= 1'b0;
            o_rx_done    <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_bcnt  <= '0;
                        r_pbit  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_at_pt) begin
                        r_cnt   <= '0;
                        r_state <= w_bit ? S_IDLE : S_DATA;
                    end else if (i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_at_pt) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_bit, r_shreg[DATA_BITS-1:1]};
                        if (r_bcnt == C_DLAST) begin
                            r_bcnt  <= '0;
                            r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bcnt <= r_bcnt + BW'(1);
                        end
                    end else if (i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_at_pt) begin
                        r_cnt   <= '0;
                        r_pbit  <= w_bit;
                        r_state <= S_STOP;
                    end else if (i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_at_pt) begin
                        r_cnt  <= '0;
                        r_ferr <= w_ferr_nx;
                        if (r_bcnt == C_SLAST) begin
                            r_bcnt       <= '0;
                            o_rx_done    <= 1'b1;
                            o_data       <= r_shreg;
                            o_parity_err <= w_perr;
                            o_frame_err  <= w_ferr_nx;
                            o_break      <= w_brk;
                            // A low stop bit may be a break; wait for the line to recover.
                            r_state      <= w_ferr_nx ? S_HOLD : S_IDLE;
                        end else begin
                            r_bcnt <= r_bcnt + BW'(1);
                        end
                    end else if (i_tick) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ext.sv
// Randomised self-checking bench for uart_rx_ext: three receiver configurations against a frame-level model.
// Honours UART_RX_MAJORITY_EN to add the mid-bit glitch immunity case.
module tb_uart_rx_ext;
    localparam int TPC = 4;
    localparam int DB_U[3] = '{8, 8, 7};
    localparam int OS_U[3] = '{16, 16, 10};
    localparam int PM_U[3] = '{0, 1, 2};
    localparam int SB_U[3] = '{1, 2, 1};

    typedef struct {
        int         unit;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx0, rx1, rx2;
    logic [2:0] o_done, o_perr, o_ferr, o_brk;
    logic [7:0] d0, d1;
    logic [6:0] d2;

    exp_t       exp_q[$];
    int         done_cnt[3];
    int         exp_cnt[3];
    logic [8:0] last_data[3];
    int         n_cmp;
    int         n_bad;
    exp_t       m_e;

    uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx0), .i_tick(tick),
        .o_rx_done(o_done[0]), .o_data(d0), .o_parity_err(o_perr[0]),
        .o_frame_err(o_ferr[0]), .o_break(o_brk[0])
    );

    uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(2)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx1), .i_tick(tick),
        .o_rx_done(o_done[1]), .o_data(d1), .o_parity_err(o_perr[1]),
        .o_frame_err(o_ferr[1]), .o_break(o_brk[1])
    );

    uart_rx_ext #(.DATA_BITS(7), .OVERSAMPLE(10), .PARITY_MODE(2), .STOP_BITS(1)) u_dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx2), .i_tick(tick),
        .o_rx_done(o_done[2]), .o_data(d2), .o_parity_err(o_perr[2]),
        .o_frame_err(o_ferr[2]), .o_break(o_brk[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            repeat (TPC - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    function automatic logic [8:0] get_data(input int u);
        case (u)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return {2'b0, d2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_line(input int u, input logic v);
        case (u)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Each bit is held one full bit time; glitch_idx flips one tick's worth near that bit's centre.
    task automatic drive_bits(input int u, input logic [15:0] bits, input int n, input int glitch_idx);
        int bt;
        bt = OS_U[u] * TPC;
        for (int i = 0; i < n; i++) begin
            set_line(u, bits[i]);
            if (i == glitch_idx) begin
                repeat (bt / 2 + 3) @(negedge clk);
                set_line(u, ~bits[i]);
                repeat (TPC) @(negedge clk);
                set_line(u, bits[i]);
                repeat (bt - bt / 2 - 3 - TPC) @(negedge clk);
            end else begin
                repeat (bt) @(negedge clk);
            end
        end
        set_line(u, 1'b1);
    endtask

    task automatic send_frame(input int u, input logic [8:0] data_in, input bit par_bad,
                              input logic [1:0] stops, input int glitch_idx);
        logic [15:0] bits;
        logic [8:0]  data;
        logic        pbit;
        int          n;
        exp_t        e;
        data = '0;
        for (int i = 0; i < DB_U[u]; i++) data[i] = data_in[i];
        bits = '1;
        n = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DB_U[u]; i++) begin
            bits[n] = data[i];
            n++;
        end
        pbit = 1'b0;
        if (PM_U[u] != 0) begin
            pbit = (^data) ^ (PM_U[u] == 2) ^ par_bad;
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < SB_U[u]; i++) begin
            bits[n] = stops[i];
            n++;
        end
        e.unit = u;
        e.data = data;
        e.perr = par_bad;
        e.ferr = (SB_U[u] == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
        e.brk  = e.ferr && (data == '0) && !pbit;
        exp_q.push_back(e);
        exp_cnt[u]++;
        last_data[u] = data;
        drive_bits(u, bits, n, glitch_idx);
        if (e.ferr) repeat (OS_U[u] * TPC) @(negedge clk);
    endtask

    task automatic check_pulses(input string tag);
        for (int u = 0; u < 3; u++) chk(tag, done_cnt[u], exp_cnt[u]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 3; u++) begin
                if (o_done[u]) begin
                    done_cnt[u]++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_done", exp_q.size(), 1);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("done_unit", u, m_e.unit);
                        chk("data", get_data(u), m_e.data);
                        chk("parity_err", o_perr[u], m_e.perr);
                        chk("frame_err", o_ferr[u], m_e.ferr);
                        chk("break", o_brk[u], m_e.brk);
                    end
                end
            end
        end
    end

    initial begin
        exp_t        e;
        logic [15:0] bits;
        n_cmp = 0;
        n_bad = 0;
        for (int u = 0; u < 3; u++) begin
            done_cnt[u]  = 0;
            exp_cnt[u]   = 0;
            last_data[u] = '0;
        end
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("rst_data", get_data(u), 0);
            chk("rst_flags", {o_done[u], o_perr[u], o_ferr[u], o_brk[u]}, 0);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(0, 9'h55, 1'b0, 2'b11, -1);
        send_frame(0, 9'hA3, 1'b0, 2'b11, -1);

        send_frame(1, 9'h07, 1'b1, 2'b11, -1);
        send_frame(1, 9'h07, 1'b0, 2'b11, -1);
        repeat (20) @(negedge clk);
        check_pulses("pulses_basic");

        rx0 = 1'b0;
        repeat (5 * TPC) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * 16 * TPC) @(negedge clk);
        check_pulses("pulses_glitch");
        chk("glitch_data_held", get_data(0), last_data[0]);
        chk("glitch_flags_held", {o_perr[0], o_ferr[0], o_brk[0]}, 0);
        send_frame(0, 9'h3C, 1'b0, 2'b11, -1);

        e.unit = 0;
        e.data = '0;
        e.perr = 1'b0;
        e.ferr = 1'b1;
        e.brk  = 1'b1;
        exp_q.push_back(e);
        exp_cnt[0]++;
        last_data[0] = '0;
        rx0 = 1'b0;
        repeat (3 * 10 * 16 * TPC) @(negedge clk);
        check_pulses("pulses_break_low");
        rx0 = 1'b1;
        repeat (16 * TPC) @(negedge clk);
        check_pulses("pulses_break_release");
        send_frame(0, 9'h3C, 1'b0, 2'b11, -1);

        send_frame(1, 9'h81, 1'b0, 2'b01, -1);
        repeat (20) @(negedge clk);
        check_pulses("pulses_stop2");

        bits = 16'h01E0;
        drive_bits(0, bits, 4, -1);
        rx0 = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            chk("midframe_rst_data", get_data(u), 0);
            chk("midframe_rst_flags", {o_done[u], o_perr[u], o_ferr[u], o_brk[u]}, 0);
            last_data[u] = '0;
        end
        rx0 = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (16 * TPC) @(negedge clk);
        check_pulses("pulses_after_rst");
        send_frame(0, 9'h0F, 1'b0, 2'b11, -1);

`ifdef UART_RX_MAJORITY_EN
        send_frame(0, 9'h0F, 1'b0, 2'b11, 4);
        send_frame(0, 9'h0F, 1'b0, 2'b11, 1);
`endif

        for (int k = 0; k < 30; k++) begin
            int         u;
            logic [8:0] d;
            bit         pb;
            logic [1:0] st;
            u  = $urandom_range(0, 2);
            d  = 9'($urandom);
            if ($urandom_range(0, 5) == 0) d = '0;
            pb = (PM_U[u] != 0) && ($urandom_range(0, 3) == 0);
            st = 2'b11;
            if ($urandom_range(0, 4) == 0) st[$urandom_range(0, SB_U[u] - 1)] = 1'b0;
            send_frame(u, d, pb, st, -1);
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3 * TPC)) @(negedge clk);
        end

        repeat (100) @(negedge clk);
        check_pulses("pulses_final");
        chk("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver, successor to the fixed 8-bit receiver in the debug/loader UART path of the MIPS32 system. It adds configurable data width, oversampling ratio, parity and stop-bit count, an input synchronizer, false-start rejection, and per-frame parity, framing and break error flags. It sits between the pin and the receive FIFO and consumes the shared baud-rate tick generator output.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, 16: ticks per bit, even, legal 8..32.
- `PARITY_MODE`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `i_clk` input 1: system clock, all logic on its rising edge.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `i_rx` input 1: serial line, idle high, asynchronous to `i_clk`.
- `i_tick` input 1: one-cycle baud tick at `OVERSAMPLE` × baud rate.
- `o_rx_done` output 1: one-cycle pulse, frame complete; data and flags valid.
- `o_data` output `DATA_BITS`: last received word, LSB first on the line.
- `o_parity_err` output 1: parity mismatch in last frame; 0 when `PARITY_MODE`=0.
- `o_frame_err` output 1: a stop bit sampled 0 in last frame.
- `o_break` output 1: last frame was all-zero (data, parity, stop).

## Operation
- Two-flop synchronizer on `i_rx`, both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Tick counter is `$clog2(OVERSAMPLE)` bits and resets to 0 on every state change.
- Bit counter is `$clog2(DATA_BITS+1)` bits.
- States:
  - IDLE: `rx_s`=0 → START.
  - START: count ticks. At count `OVERSAMPLE/2-1` sample. Sample 1 → IDLE as a glitch, with no pulse and no flag change. Sample 0 → DATA.
  - DATA: sample at count `OVERSAMPLE-1` (mid-bit) and shift into the MSB of the shift register. After `DATA_BITS` samples → PARITY if `PARITY_MODE`≠0, else STOP.
  - PARITY: sample at count `OVERSAMPLE-1`. Error = XOR(data, pbit) ≠ (`PARITY_MODE`==2).
  - STOP: sample each stop bit at count `OVERSAMPLE-1`. Any 0 sets the frame error. After the last stop bit sample, update outputs and go to IDLE, or to HOLD if a frame error occurred.
  - HOLD: wait for `rx_s`=1, then go to IDLE. This prevents retriggering during a break.
- Output update on frame end:
  - `o_data`, `o_parity_err`, `o_frame_err` and `o_break` load together with the `o_rx_done` pulse.
  - They hold until the next completed frame.
  - `o_rx_done` pulses on every completed frame, including erroneous ones.
- `o_break` = frame error AND data all zero AND (parity bit 0 or no parity).
- Ticks arriving in IDLE or HOLD are ignored. Non-tick cycles never advance counters.

## Timing
- Reset values: `o_rx_done` 0, `o_data` 0, all flags 0, state IDLE, counters 0, synchronizer 1.
- Reset takes effect asynchronously, mid-frame included. The partial frame is discarded with no pulse.
- Start detection latency: 2 clocks of synchronizer plus 1 clock to enter START.
- `o_rx_done` is registered. It is high in the clock after the `i_tick` cycle that samples the last stop bit, for exactly 1 clock.
- Back-to-back frames: a start edge arriving in the first clock after STOP is accepted. There is no dead time beyond the synchronizer.
- `i_tick` must not be asserted on consecutive clocks more than the reset/sync latency allows. The block assumes at least 1 idle clock between ticks.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample (start validation, data, parity, stop) is the 2-of-3 majority of `rx_s`, taken at tick counts N-2, N-1 and N, where N is the nominal sample count.
  - This rejects single-tick noise.
- Undefined: a single sample at count N. Majority storage logic is not built.

## Test plan
- 8N1, `OVERSAMPLE`=16, tick every 4 clocks, send 0x55 then 0xA3 back-to-back → two `o_rx_done` pulses, `o_data` 0x55 then 0xA3, all flags 0.
- `PARITY_MODE`=1, send 0x07 with parity bit 0 → `o_parity_err`=1, `o_data`=0x07. Resend with parity bit 1 → `o_parity_err`=0.
- Low pulse of 5 ticks on the idle line → no `o_rx_done`, outputs unchanged, and the next valid 0x3C is received correctly.
- Hold line low for 3 frame times, then release → exactly one `o_rx_done` with `o_data`=0, `o_frame_err`=1 and `o_break`=1. No further pulse until the line returns high and a new frame arrives.
- `STOP_BITS`=2, second stop bit driven 0 on 0x81 → `o_frame_err`=1, `o_break`=0, `o_data`=0x81.
- Assert `i_reset_n`=0 mid-DATA of 0xF0 → outputs 0 immediately. After release, frame 0x0F is received cleanly. With `UART_RX_MAJORITY_EN`, a 1-tick glitch at mid-bit of bit 3 does not corrupt 0x0F.
